otter_ctrl_fsm: RTL
===================

// Module: otter_ctrl_fsm
// PURPOSE
//  Next-generation multicycle control FSM for the OTTER RV32I core; replaces the fixed-latency CU FSM.
//  Sits between the instruction register opcode/funct3 and the datapath enables (PC, register file, memory, CSR).
//  Adds ready/ack memory handshaking with a parametrised timeout fault.
//  Adds a parametrised interrupt synchroniser, trap entry and MRET/CSR sequencing.
// PARAMETERS
//  MEM_TIMEOUT       16  cycles a request may wait for MEM_ACK before FAULT; 0 disables the timeout
//  INTR_SYNC_STAGES   2  flops in the INTR synchroniser (>=1)
// PORTS
//  CLK        in   1  core clock
//  RST        in   1  synchronous, active-high reset
//  INTR       in   1  external interrupt, asynchronous level
//  MIE        in   1  mstatus.MIE from the CSR file
//  OPCODE     in   7  ir[6:0]
//  FUNCT3     in   3  ir[14:12]
//  MEM_ACK    in   1  memory completed the current request (read data valid / write accepted)
//  RESET      out  1  datapath reset (PC := 0)
//  PC_WRITE   out  1  PC load enable
//  RF_WRITE   out  1  register file write enable
//  MEM_RDEN1  out  1  instruction fetch request
//  MEM_RDEN2  out  1  data read request
//  MEM_WE2    out  1  data write request
//  CSR_WE     out  1  CSR file write enable
//  INT_TAKEN  out  1  trap entry pulse: CSR saves mepc, clears MIE; PC mux selects mtvec
//  MRET_EXEC  out  1  mret pulse: PC mux selects mepc, CSR restores MIE
//  ILLEGAL    out  1  one-cycle pulse on an unsupported opcode
//  BUS_ERR    out  1  sticky memory-timeout fault flag
//  STATE      out  3  current state encoding (debug)
// BEHAVIOUR
//  States/encodings: INIT=0 FETCH=1 EXEC=2 MEM_RD=3 WB=4 MEM_WR=5 TRAP=6 FAULT=7.
//  Reset: RST=1 -> state INIT, timeout counter 0, sync flops 0, BUS_ERR 0.
//    RESET=1 while RST=1 and for the single INIT cycle.
//    All other outputs are 0 during reset and in INIT.
//  All enables are decoded combinationally from state (Moore) plus OPCODE/FUNCT3/MEM_ACK in EXEC/handshake states.
//  INIT -> FETCH unconditionally.
//  FETCH: MEM_RDEN1=1, held until MEM_ACK; on ACK -> EXEC (the IR latches on the ACK cycle).
//  EXEC by opcode:
//    LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP_IMM 0010011, OP 0110011
//      -> PC_WRITE=1, RF_WRITE=1.
//    BRANCH 1100011 -> PC_WRITE=1.
//    SYSTEM 1110011, FUNCT3!=0 (CSRRx) -> PC_WRITE=1, RF_WRITE=1, CSR_WE=1.
//    SYSTEM 1110011, FUNCT3==0 (MRET) -> PC_WRITE=1, MRET_EXEC=1.
//    LOAD 0000011 -> MEM_RD, no writes this cycle.
//    STORE 0100011 -> MEM_WR, no writes this cycle.
//    Any other opcode -> ILLEGAL=1, PC_WRITE=1 (skip), no other writes.
//  MEM_RD: MEM_RDEN2=1 until MEM_ACK; on ACK -> WB.
//  WB: RF_WRITE=1, PC_WRITE=1.
//  MEM_WR: MEM_WE2=1 until MEM_ACK; PC_WRITE=1 only on the ACK cycle.
//  End of instruction: the cycle in which PC_WRITE=1 in EXEC/WB/MEM_WR. Next state = TRAP if pend, else FETCH.
//    pend = intr_sync & MIE, sampled in that same cycle.
//    MRET and trap pend in the same cycle -> MRET completes, then TRAP.
//  TRAP: INT_TAKEN=1, PC_WRITE=1, one cycle -> FETCH. Never chained back-to-back; pend is ignored in TRAP.
//  Interrupts are never taken mid-instruction or in FETCH; an INTR pulse that is gone before sampling is lost (level-sensitive).
//  INTR latency: INTR_SYNC_STAGES cycles to intr_sync.
//  Timeout: the counter increments each cycle in FETCH/MEM_RD/MEM_WR without ACK and clears on ACK or state change.
//    Count reaches MEM_TIMEOUT with no ACK -> FAULT. ACK in the final allowed cycle wins.
//    MEM_TIMEOUT=0 -> counter is never compared.
//  FAULT: BUS_ERR=1, all enables 0. Exit only via RST.
//  RST mid-handshake: the request drops the next cycle; no PC/RF/CSR write occurs.
// TESTING
//  T1 reset: hold RST 3 cycles, release -> RESET=1 through the INIT cycle, STATE 0->1, MEM_RDEN1=1 at cycle 2.
//  T2 ADDI (0010011), ACK=1 immediately -> FETCH,EXEC; RF_WRITE=PC_WRITE=1 in EXEC; 2 cycles per instruction.
//  T3 LW with ACK delayed 3 cycles in MEM_RD -> MEM_RDEN2 high 4 cycles, then WB with RF_WRITE=1; SW gives MEM_WE2 and PC_WRITE on the ACK cycle only.
//  T4 MEM_TIMEOUT=4, no ACK in FETCH -> FAULT after 4 cycles, BUS_ERR sticky; repeat with ACK in cycle 4 -> EXEC, no fault.
//  T5 INTR=1, MIE=1 during ADD -> TRAP after EXEC, INT_TAKEN=1 one cycle; MIE=0 -> no trap; INTR during a load wait -> trap only after WB.
//  T6 opcode 0000000 -> ILLEGAL pulse, PC_WRITE=1, RF_WRITE=0; MRET (1110011, f3=0) -> MRET_EXEC=1, CSR_WE=0.

Source files
------------

// File: rtl/otter_ctrl_fsm.sv
// Multicycle control FSM for the OTTER RV32I core: fetch/execute/memory sequencing with
// ready/ack handshakes, a memory-timeout fault and synchronised interrupt trap entry.
module otter_ctrl_fsm #(
    parameter int MEM_TIMEOUT      = 16,
    parameter int INTR_SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INTR,
    input  logic       MIE,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       MEM_ACK,
    output logic       RESET,
    output logic       PC_WRITE,
    output logic       RF_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic       ILLEGAL,
    output logic       BUS_ERR,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_WB     = 3'd4,
        ST_MEM_WR = 3'd5,
        ST_TRAP   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    function automatic logic is_wb_op(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
               (op == OP_JALR) || (op == OP_IMM) || (op == OP_REG);
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [INTR_SYNC_STAGES-1:0] sync_r;
    logic                  bus_err_r;
    logic                  intr_sync_s;
    logic                  pend_s;
    logic                  wait_s;
    logic                  timeout_s;

    logic reset_s, pc_write_s, rf_write_s, rden1_s, rden2_s, we2_s;
    logic csr_we_s, int_taken_s, mret_s, illegal_s;

    assign intr_sync_s = sync_r[INTR_SYNC_STAGES-1];
    assign pend_s      = intr_sync_s & MIE;
    assign wait_s      = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);
    assign timeout_s   = (MEM_TIMEOUT != 0) && (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; instruction boundaries divert to TRAP when an interrupt is pending.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT:   state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (MEM_ACK)        state_next_s = ST_EXEC;
                else if (timeout_s) state_next_s = ST_FAULT;
                else                state_next_s = ST_FETCH;
            end
            ST_EXEC: begin
                if (OPCODE == OP_LOAD)       state_next_s = ST_MEM_RD;
                else if (OPCODE == OP_STORE) state_next_s = ST_MEM_WR;
                else if (pend_s)             state_next_s = ST_TRAP;
                else                         state_next_s = ST_FETCH;
            end
            ST_MEM_RD: begin
                if (MEM_ACK)        state_next_s = ST_WB;
                else if (timeout_s) state_next_s = ST_FAULT;
                else                state_next_s = ST_MEM_RD;
            end
            ST_WB:     state_next_s = pend_s ? ST_TRAP : ST_FETCH;
            ST_MEM_WR: begin
                if (MEM_ACK)        state_next_s = pend_s ? ST_TRAP : ST_FETCH;
                else if (timeout_s) state_next_s = ST_FAULT;
                else                state_next_s = ST_MEM_WR;
            end
            ST_TRAP:   state_next_s = ST_FETCH;
            ST_FAULT:  state_next_s = ST_FAULT;
            default:   state_next_s = ST_INIT;
        endcase
    end

    // Output decode from state, plus opcode in EXEC and ack in MEM_WR.
    always_comb begin
        reset_s     = 1'b0;
        pc_write_s  = 1'b0;
        rf_write_s  = 1'b0;
        rden1_s     = 1'b0;
        rden2_s     = 1'b0;
        we2_s       = 1'b0;
        csr_we_s    = 1'b0;
        int_taken_s = 1'b0;
        mret_s      = 1'b0;
        illegal_s   = 1'b0;
        case (state_r)
            ST_INIT:   reset_s = 1'b1;
            ST_FETCH:  rden1_s = 1'b1;
            ST_EXEC: begin
                if (is_wb_op(OPCODE)) begin
                    pc_write_s = 1'b1;
                    rf_write_s = 1'b1;
                end else if (OPCODE == OP_BRANCH) begin
                    pc_write_s = 1'b1;
                end else if (OPCODE == OP_SYSTEM) begin
                    pc_write_s = 1'b1;
                    if (FUNCT3 != 3'd0) begin
                        rf_write_s = 1'b1;
                        csr_we_s   = 1'b1;
                    end else begin
                        mret_s = 1'b1;
                    end
                end else if (is_mem_op(OPCODE)) begin
                    pc_write_s = 1'b0;
                end else begin
                    illegal_s  = 1'b1;
                    pc_write_s = 1'b1;
                end
            end
            ST_MEM_RD: rden2_s = 1'b1;
            ST_WB: begin
                pc_write_s = 1'b1;
                rf_write_s = 1'b1;
            end
            ST_MEM_WR: begin
                we2_s      = 1'b1;
                pc_write_s = MEM_ACK;
            end
            ST_TRAP: begin
                int_taken_s = 1'b1;
                pc_write_s  = 1'b1;
            end
            ST_FAULT:  pc_write_s = 1'b0;
            default:   reset_s = 1'b1;
        endcase
    end

    // Handshake wait counter: clears on ack or any state change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (wait_s && !MEM_ACK && (state_next_s == state_r)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Interrupt synchroniser chain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= INTR;
            for (int i = 1; i < INTR_SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Sticky bus-error flag, set on entry to FAULT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus_err_r <= 1'b0;
        end else if (state_next_s == ST_FAULT) begin
            bus_err_r <= 1'b1;
        end else begin
            bus_err_r <= bus_err_r;
        end
    end

    // Writes and pulses are suppressed while RST is asserted so a reset mid-handshake commits nothing.
    assign RESET     = reset_s | RST;
    assign PC_WRITE  = pc_write_s  & ~RST;
    assign RF_WRITE  = rf_write_s  & ~RST;
    assign CSR_WE    = csr_we_s    & ~RST;
    assign INT_TAKEN = int_taken_s & ~RST;
    assign MRET_EXEC = mret_s      & ~RST;
    assign ILLEGAL   = illegal_s   & ~RST;
    assign MEM_RDEN1 = rden1_s;
    assign MEM_RDEN2 = rden2_s;
    assign MEM_WE2   = we2_s;
    assign BUS_ERR   = bus_err_r;
    assign STATE     = state_r;

endmodule
